// File: rtl/alu_ctrl_if.sv
// Bundle between alu_ctrl and its surroundings: instruction stream, ALU drive/return, store stream.
// slave is the controller side; master is fetch, ALU and the store consumer.
interface alu_ctrl_if #(
  parameter int SIZE = 8
);
  localparam int INSTR_W = SIZE + 9;

  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic               alu_ce;
  logic [2:0]         alu_op;
  logic [SIZE-1:0]    alu_left;
  logic [SIZE-1:0]    alu_right;
  logic               alu_cin;
  logic [SIZE-1:0]    alu_res;
  logic               alu_cout;
  logic               out_valid;
  logic               out_ready;
  logic [SIZE-1:0]    out_data;
  logic               carry_flag;

  modport master (
    output instr_valid, instr, alu_res, alu_cout, out_ready,
    input  instr_ready, alu_ce, alu_op, alu_left, alu_right, alu_cin,
           out_valid, out_data, carry_flag
  );

  modport slave (
    input  instr_valid, instr, alu_res, alu_cout, out_ready,
    output instr_ready, alu_ce, alu_op, alu_left, alu_right, alu_cin,
           out_valid, out_data, carry_flag
  );
endinterface

// File: rtl/alu_ctrl.sv
// Issue-side controller for the 8-bit ALU: accepts one instruction, drives the ALU for one
// cycle, writes the result back to a 4-entry register file, and streams ST results out.
module alu_ctrl #(
  parameter int SIZE = 8
) (
  input logic       CLK,
  input logic       RST,
  alu_ctrl_if.slave bus
);
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_ST  = 3'd7;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, OUT = 2'd2} state_t;

  state_t          state;
  state_t          state_nxt;
  logic            accept;

  logic [2:0]      op;
  logic [1:0]      rd;
  logic [1:0]      rs;
  logic            imm_sel;
  logic            cin_en;
  logic [SIZE-1:0] imm;

  logic [SIZE-1:0] regs [4];
  logic            carry_q;
  logic [SIZE-1:0] out_q;

  logic            ce_p1;
  logic [2:0]      op_p1;
  logic [SIZE-1:0] left_p1;
  logic [SIZE-1:0] right_p1;
  logic            cin_p1;
  logic [1:0]      rd_p1;

  assign op      = bus.instr[SIZE+8:SIZE+6];
  assign rd      = bus.instr[SIZE+5:SIZE+4];
  assign rs      = bus.instr[SIZE+3:SIZE+2];
  assign imm_sel = bus.instr[SIZE+1];
  assign cin_en  = bus.instr[SIZE];
  assign imm     = bus.instr[SIZE-1:0];

  function automatic logic is_arith(input logic [2:0] code);
    return (code == OP_ADD) || (code == OP_SUB);
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // The two handshake outputs decode the state directly so reset silences them in the same cycle.
  always_comb begin
    state_nxt       = state;
    accept          = 1'b0;
    bus.instr_ready = 1'b0;
    bus.out_valid   = 1'b0;
    case (state)
      IDLE: begin
        bus.instr_ready = !RST;
        accept          = !RST && bus.instr_valid;
        if (accept) state_nxt = EXEC;
      end
      EXEC: state_nxt = (op_p1 == OP_ST) ? OUT : IDLE;
      OUT: begin
        bus.out_valid = !RST;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // p1: ALU drive registers, loaded at acceptance so they are live exactly during EXEC
  always_ff @(posedge CLK) begin
    if (RST) begin
      ce_p1    <= 1'b0;
      op_p1    <= '0;
      left_p1  <= '0;
      right_p1 <= '0;
      cin_p1   <= 1'b0;
      carry_q  <= 1'b0;
      out_q    <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      ce_p1    <= accept;
      op_p1    <= '0;
      left_p1  <= '0;
      right_p1 <= '0;
      cin_p1   <= 1'b0;
      if (accept) begin
        op_p1    <= op;
        left_p1  <= regs[rd];
        right_p1 <= imm_sel ? imm : regs[rs];
        cin_p1   <= (is_arith(op) && cin_en) ? carry_q : 1'b0;
        rd_p1    <= rd;
      end
      // Writeback: the ALU result is combinational from the p1 registers during EXEC.
      if (state == EXEC) begin
        if (op_p1 == OP_ST) out_q        <= bus.alu_res;
        else                regs[rd_p1]  <= bus.alu_res;
        if (is_arith(op_p1)) carry_q <= bus.alu_cout;
      end
    end
  end

  assign bus.alu_ce     = ce_p1 && !RST;
  assign bus.alu_op     = op_p1;
  assign bus.alu_left   = left_p1;
  assign bus.alu_right  = right_p1;
  assign bus.alu_cin    = cin_p1;
  assign bus.out_data   = out_q;
  assign bus.carry_flag = carry_q;
endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl: behavioural ALU, directed vector table, reset/backpressure sequences,
// and a random back-to-back stream checked against a reference model and store scoreboard.
module tb_alu_ctrl;
  localparam int SIZE = 8;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND = 3'd2, OR = 3'd3;
  localparam logic [2:0] XOR = 3'd4, NOT = 3'd5, LD = 3'd6, ST = 3'd7;

  typedef struct {
    logic [2:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic       imm_sel;
    logic       cin_en;
    logic [7:0] imm;
    logic       exp_c;
    int         exp_st;
  } vec_t;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  alu_ctrl_if #(.SIZE(SIZE)) bus ();
  alu_ctrl #(.SIZE(SIZE)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  int checks = 0;
  int passes = 0;
  int ce_count = 0;
  logic [7:0] m_r [4];
  logic       m_c;
  logic [7:0] sb_q [$];
  time        last_acc;
  vec_t       tbl [20];

  // Behavioural ALU: ST passes the left operand through, LD the right one.
  always_comb begin
    logic [SIZE:0] s;
    case (bus.alu_op)
      ADD:     s = {1'b0, bus.alu_left} + {1'b0, bus.alu_right} + {{SIZE{1'b0}}, bus.alu_cin};
      SUB:     s = {1'b0, bus.alu_left} - {1'b0, bus.alu_right} + {{SIZE{1'b0}}, bus.alu_cin};
      AND:     s = {1'b0, bus.alu_left & bus.alu_right};
      OR:      s = {1'b0, bus.alu_left | bus.alu_right};
      XOR:     s = {1'b0, bus.alu_left ^ bus.alu_right};
      NOT:     s = {1'b0, ~bus.alu_left};
      LD:      s = {1'b0, bus.alu_right};
      default: s = {1'b0, bus.alu_left};
    endcase
    bus.alu_res  = s[SIZE-1:0];
    bus.alu_cout = s[SIZE];
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge CLK) begin
    if (bus.alu_ce) ce_count++;
    if (!RST && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        $display("FAIL sb_unexpected: store 0x%0h with nothing expected at %0t", bus.out_data, $time);
      end else begin
        chk("sb_out_data", int'(bus.out_data), int'(sb_q.pop_front()));
      end
    end
  end

  function automatic logic [16:0] mk(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                                     input logic imm_sel, input logic cin_en, input logic [7:0] imm);
    return {op, rd, rs, imm_sel, cin_en, imm};
  endfunction

  function automatic vec_t v(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                             input logic imm_sel, input logic cin_en, input logic [7:0] imm,
                             input logic exp_c, input int exp_st);
    vec_t r;
    r.op = op; r.rd = rd; r.rs = rs; r.imm_sel = imm_sel; r.cin_en = cin_en;
    r.imm = imm; r.exp_c = exp_c; r.exp_st = exp_st;
    return r;
  endfunction

  // Reference model: returns the expected ALU drive and updates registers/carry.
  task automatic model_exec(input logic [16:0] ins, output logic [7:0] el, output logic [7:0] er,
                            output logic ec, output logic [7:0] sv);
    logic [2:0] op;
    int l, r, c, t;
    op = ins[16:14];
    el = m_r[ins[13:12]];
    er = ins[9] ? ins[7:0] : m_r[ins[11:10]];
    ec = (op <= SUB && ins[8]) ? m_c : 1'b0;
    l = int'(el); r = int'(er); c = int'(ec);
    case (op)
      ADD:     t = l + r + c;
      SUB:     t = l - r + c;
      AND:     t = l & r;
      OR:      t = l | r;
      XOR:     t = l ^ r;
      NOT:     t = (~l) & 255;
      LD:      t = r;
      default: t = l;
    endcase
    sv = t[7:0];
    if (op <= SUB) m_c = t[8];
    if (op != ST) m_r[ins[13:12]] = t[7:0];
  endtask

  // Called at a negedge; returns at the negedge of cycle 2 (cycle 3 for ST when st_done).
  task automatic issue(input logic [16:0] ins, input int exp_st, input bit st_done);
    int n;
    logic [7:0] el, er, sv;
    logic ec;
    logic [2:0] op;
    op = ins[16:14];
    bus.instr = ins;
    bus.instr_valid = 1'b1;
    n = 0;
    while (!bus.instr_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!bus.instr_ready) begin
      checks++;
      $display("FAIL accept_timeout: instr_ready stayed 0, expected 1 within 50 cycles");
      bus.instr_valid = 1'b0;
      return;
    end
    @(posedge CLK);
    last_acc = $time;
    #1;
    bus.instr = 17'($urandom);
    model_exec(ins, el, er, ec, sv);
    if (op == ST) sb_q.push_back(exp_st < 0 ? sv : exp_st[7:0]);
    @(negedge CLK);
    chk("exec_ce", int'(bus.alu_ce), 1);
    chk("exec_op", int'(bus.alu_op), int'(op));
    chk("exec_left", int'(bus.alu_left), int'(el));
    chk("exec_right", int'(bus.alu_right), int'(er));
    chk("exec_cin", int'(bus.alu_cin), int'(ec));
    @(negedge CLK);
    chk("post_exec_ce", int'(bus.alu_ce), 0);
    if (op == ST) begin
      chk("st_out_valid", int'(bus.out_valid), 1);
      chk("st_ready_low", int'(bus.instr_ready), 0);
    end else begin
      chk("ready_again", int'(bus.instr_ready), 1);
      chk("carry_flag", int'(bus.carry_flag), int'(m_c));
    end
    bus.instr_valid = 1'b0;
    if (op == ST && st_done) begin
      @(negedge CLK);
      chk("st_done_ready", int'(bus.instr_ready), 1);
      chk("st_done_valid", int'(bus.out_valid), 0);
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    bus.instr_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      chk("rst_ready", int'(bus.instr_ready), 0);
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_ce", int'(bus.alu_ce), 0);
    end
    @(posedge CLK);
    #1;
    RST = 1'b0;
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    m_c = 1'b0;
    @(negedge CLK);
    chk("rst_ready_rise", int'(bus.instr_ready), 1);
    chk("rst_carry", int'(bus.carry_flag), 0);
    chk("rst_out_data", int'(bus.out_data), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ce0;
    time prev_t;
    bit prev_st;
    logic [16:0] ins;
    RST = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    m_c = 1'b0;

    tbl[0]  = v(LD,  2'd0, 2'd0, 1'b1, 1'b0, 8'h05, 1'b0, -1);
    tbl[1]  = v(ST,  2'd0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 'h05);
    tbl[2]  = v(LD,  2'd1, 2'd0, 1'b1, 1'b0, 8'hFF, 1'b0, -1);
    tbl[3]  = v(LD,  2'd2, 2'd0, 1'b1, 1'b0, 8'h01, 1'b0, -1);
    tbl[4]  = v(ADD, 2'd1, 2'd2, 1'b0, 1'b0, 8'h00, 1'b1, -1);
    tbl[5]  = v(ST,  2'd1, 2'd0, 1'b0, 1'b0, 8'h00, 1'b1, 'h00);
    tbl[6]  = v(ADD, 2'd1, 2'd0, 1'b1, 1'b1, 8'h00, 1'b0, -1);
    tbl[7]  = v(ST,  2'd1, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 'h01);
    tbl[8]  = v(LD,  2'd0, 2'd0, 1'b1, 1'b0, 8'h03, 1'b0, -1);
    tbl[9]  = v(SUB, 2'd0, 2'd0, 1'b1, 1'b0, 8'h05, 1'b1, -1);
    tbl[10] = v(ST,  2'd0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b1, 'hFE);
    tbl[11] = v(AND, 2'd0, 2'd0, 1'b1, 1'b0, 8'h0F, 1'b1, -1);
    tbl[12] = v(OR,  2'd0, 2'd0, 1'b1, 1'b0, 8'h30, 1'b1, -1);
    tbl[13] = v(XOR, 2'd0, 2'd0, 1'b1, 1'b0, 8'hFF, 1'b1, -1);
    tbl[14] = v(NOT, 2'd0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b1, -1);
    tbl[15] = v(LD,  2'd2, 2'd0, 1'b1, 1'b0, 8'h77, 1'b1, -1);
    tbl[16] = v(ST,  2'd0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b1, 'h3E);
    tbl[17] = v(ST,  2'd2, 2'd0, 1'b0, 1'b0, 8'h00, 1'b1, 'h77);
    tbl[18] = v(SUB, 2'd2, 2'd1, 1'b0, 1'b1, 8'h00, 1'b0, -1);
    tbl[19] = v(ST,  2'd2, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 'h77);

    do_reset(3);

    ce0 = ce_count;
    for (int i = 0; i < 20; i++) begin
      issue(mk(tbl[i].op, tbl[i].rd, tbl[i].rs, tbl[i].imm_sel, tbl[i].cin_en, tbl[i].imm),
            tbl[i].exp_st, 1'b1);
      chk("tbl_carry", int'(bus.carry_flag), int'(tbl[i].exp_c));
    end
    chk("ce_pulses_tbl", ce_count - ce0, 20);

    // Reset during EXEC of ADD R0,#0x10 with carry set beforehand.
    issue(mk(SUB, 2'd0, 2'd0, 1'b1, 1'b0, 8'hFF), -1, 1'b1);
    chk("pre_rst_carry", int'(bus.carry_flag), 1);
    bus.instr = mk(ADD, 2'd0, 2'd0, 1'b1, 1'b0, 8'h10);
    bus.instr_valid = 1'b1;
    chk("exec_rst_accept", int'(bus.instr_ready), 1);
    @(posedge CLK);
    #1;
    bus.instr_valid = 1'b0;
    RST = 1'b1;
    #1;
    chk("exec_rst_ce", int'(bus.alu_ce), 0);
    chk("exec_rst_ready", int'(bus.instr_ready), 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    m_c = 1'b0;
    @(negedge CLK);
    chk("exec_rst_ready_rise", int'(bus.instr_ready), 1);
    chk("exec_rst_carry", int'(bus.carry_flag), 0);
    issue(mk(ST, 2'd0, 2'd0, 1'b0, 1'b0, 8'h00), 'h00, 1'b1);

    // ST R3 held by out_ready low for 5 cycles; junk instructions must be ignored meanwhile.
    issue(mk(LD, 2'd3, 2'd0, 1'b1, 1'b0, 8'hA5), -1, 1'b1);
    @(posedge CLK);
    #1;
    bus.out_ready = 1'b0;
    @(negedge CLK);
    issue(mk(ST, 2'd3, 2'd0, 1'b0, 1'b0, 8'h00), 'hA5, 1'b0);
    bus.instr = mk(LD, 2'd3, 2'd0, 1'b1, 1'b0, 8'h11);
    bus.instr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge CLK);
      chk("hold_valid", int'(bus.out_valid), 1);
      chk("hold_data", int'(bus.out_data), 'hA5);
      chk("hold_ready", int'(bus.instr_ready), 0);
    end
    @(posedge CLK);
    #1;
    bus.out_ready = 1'b1;
    bus.instr_valid = 1'b0;
    @(negedge CLK);
    chk("hold_hs_valid", int'(bus.out_valid), 1);
    @(negedge CLK);
    chk("hold_after_ready", int'(bus.instr_ready), 1);
    chk("hold_after_valid", int'(bus.out_valid), 0);
    issue(mk(ST, 2'd3, 2'd0, 1'b0, 1'b0, 8'h00), 'hA5, 1'b1);

    // Reset during OUT of an ST: the pending store is abandoned.
    @(posedge CLK);
    #1;
    bus.out_ready = 1'b0;
    @(negedge CLK);
    issue(mk(ST, 2'd3, 2'd0, 1'b0, 1'b0, 8'h00), 'hA5, 1'b0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    #1;
    chk("out_rst_valid", int'(bus.out_valid), 0);
    chk("out_rst_ready", int'(bus.instr_ready), 0);
    sb_q.delete();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    m_c = 1'b0;
    @(negedge CLK);
    chk("out_rst_ready_rise", int'(bus.instr_ready), 1);
    chk("out_rst_valid_low", int'(bus.out_valid), 0);
    chk("out_rst_data", int'(bus.out_data), 0);

    // Random back-to-back stream with instr_valid held high.
    ce0 = ce_count;
    prev_t = 0;
    prev_st = 1'b0;
    for (int i = 0; i < 40; i++) begin
      ins = 17'($urandom);
      issue(ins, -1, 1'b1);
      if (i > 0) chk("throughput", int'(last_acc - prev_t), prev_st ? 30 : 20);
      prev_t = last_acc;
      prev_st = (ins[16:14] == ST);
    end
    chk("ce_pulses_rand", ce_count - ce0, 40);
    for (int i = 0; i < 4; i++)
      issue(mk(ST, i[1:0], 2'd0, 1'b0, 1'b0, 8'h00), -1, 1'b1);
    chk("sb_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/alu_ctrl.md
# alu_ctrl

Issue-side controller for the 8-bit ALU: accepts encoded instructions over a valid/ready handshake and owns a 4-entry register file and carry flag. It drives the ALU's CE/OP_CODE/operand/carry_in inputs, captures op_out/carry_out and writes results back. OP_ST results go out on a second valid/ready stream. It sits between instruction fetch and the ALU in the Salamander-4 datapath.

## Interface
- SIZE, 8, datapath width; must match the ALU's SIZE
- INSTR_W, SIZE+9, instruction width; fixed, not overridable
- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  synchronous, active-high reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  controller can accept
- instr  in  INSTR_W  fields:
  - [SIZE+8:SIZE+6] op
  - [SIZE+5:SIZE+4] rd
  - [SIZE+3:SIZE+2] rs
  - [SIZE+1] imm_sel
  - [SIZE] cin_en
  - [SIZE-1:0] imm
- alu_ce  out  1  to ALU CE
- alu_op  out  3  to ALU OP_CODE
- alu_left  out  SIZE  to ALU left_operand
- alu_right  out  SIZE  to ALU right_operand
- alu_cin  out  1  to ALU carry_in
- alu_res  in  SIZE  from ALU op_out
- alu_cout  in  1  from ALU carry_out
- out_valid  out  1  store data valid
- out_ready  in  1  store data consumed
- out_data  out  SIZE  stored value
- carry_flag  out  1  current carry flag

## Operation
- Opcodes, from the shared OP_CODES definitions:
  - ADD=0, SUB=1, AND=2, OR=3
  - XOR=4, NOT=5, LD=6, ST=7
- State machine: IDLE, EXEC, OUT.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready, latch instr and go to EXEC.
- EXEC lasts exactly one cycle and drives the ALU:
  - alu_ce=1, alu_op=op
  - alu_left=R[rd]
  - alu_right = imm_sel ? imm : R[rs]
  - alu_cin = (op is ADD or SUB) && cin_en ? carry_flag : 0
- At the end of EXEC:
  - op 0–6: R[rd] <= alu_res.
  - ADD and SUB only: carry_flag <= alu_cout. All other ops leave carry_flag unchanged.
  - op ST: out_data <= alu_res, no register write, go to OUT. All other ops return to IDLE.
- OUT: out_valid=1 and out_data held stable until out_valid&&out_ready, then go to IDLE.
- Arithmetic is done entirely in the ALU. The controller does no width extension; results wrap modulo 2^SIZE. SUB carry is the ALU's bit SIZE of L−R+cin, stored unmodified.
- Outside EXEC, alu_ce, alu_op, alu_left, alu_right and alu_cin are all 0. alu_ce is never 1 outside EXEC.
- Register reads in EXEC see the previous instruction's writeback. Writeback completes before the next IDLE acceptance, so there are no hazards.

## Timing
- Reset (RST high at an edge):
  - Forces IDLE, clears R0–R3, carry_flag and out_data.
  - During any cycle RST is high: instr_ready=0, out_valid=0, alu_ce=0.
  - instr_ready rises in the first cycle with RST low.
- Reset mid-operation: an instruction in EXEC or OUT is abandoned, with no writeback and no flag update. out_valid drops immediately and no handshake completes.
- Non-ST latency: accept at edge 0, EXEC in cycle 1, result visible in R[rd] and carry_flag after edge 2. instr_ready is high again in cycle 2.
- Non-ST throughput: one instruction per 2 cycles.
- ST latency: out_valid is high from cycle 2. With out_ready already high, the handshake completes at edge 3 and instr_ready is high in cycle 3.
- Backpressure: instr_ready=0 in EXEC and OUT. instr_valid in those states is ignored and not queued.
- out_valid is never withdrawn before the handshake except by reset.
- Simultaneous out handshake and new instr_valid: the new instruction is accepted no earlier than the following cycle.
- All outputs except instr_ready and out_valid are registered. instr_ready and out_valid decode the state register, gated by !RST.

## Test plan
- Reset, then LD R0,#0x05 (imm_sel=1), then ST R0:
  - out_data=0x05 in cycle 2 after ST acceptance.
  - alu_ce pulses exactly once per instruction.
- LD R1,#0xFF; LD R2,#0x01; ADD R1,R2:
  - R1=0x00, carry_flag=1.
  - Then ADD R1,#0x00 with cin_en=1 gives R1=0x01, carry_flag=0.
- LD R0,#0x03; SUB R0,#0x05 (cin_en=0):
  - R0=0xFE, carry_flag=1 (ALU bit 8).
  - AND/OR/XOR/NOT/LD afterwards leave carry_flag unchanged.
- Random instr_valid held high continuously:
  - Acceptances occur exactly every 2 cycles for non-ST ops.
  - No instruction is lost or duplicated (checked against a reference model).
- ST R3 with out_ready low for 5 cycles:
  - out_valid and out_data are stable for all 5 cycles.
  - instr_ready=0 throughout.
  - Handshake on the 6th cycle, instr_ready=1 the next cycle.
- RST asserted during EXEC of ADD R0,#0x10 and again during OUT of an ST:
  - No register or flag change.
  - out_valid=0 the same cycle.
  - instr_ready=1 the first cycle after RST deasserts.
